dmem_ctrl: RTL and testbench

Data-memory controller that sits between two requesters and the single-port, word-indexed data memory. Port 0 is the core load/store unit; port 1 is the debug/DMA port. The controller round-robin arbitrates between them, translates byte addresses to word indices, and range-checks each request. It also performs read-modify-write for sub-word stores, because the memory only supports full-word writes.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/dmem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, constants and the byte-lane merge used by the data-memory controller.
package dmem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   typedef logic port_id_t;

   localparam int NUM_PORTS  = 2;
   localparam int WORD_BYTES = 4;

   // Lane i of the result comes from new_word when be[i] is set, otherwise from old_word.
   function automatic logic [31:0] byte_merge(input logic [31:0]           old_word,
                                              input logic [31:0]           new_word,
                                              input logic [WORD_BYTES-1:0] be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: the port not granted last wins a tie.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 advance,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt
);

   port_id_t last_port;

   always_comb begin
      gnt = '0;
      if (advance) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_port ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Starts at port 1 so that port 0 wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_port <= 1'b1;
      end else if (gnt[1]) begin
         last_port <= 1'b1;
      end else if (gnt[0]) begin
         last_port <= 1'b0;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates two ports onto a single-port word memory,
// range-checks requests and performs read-modify-write for sub-word stores.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_be,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,

   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_be,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,

   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

   state_t      state;
   state_t      state_next;

   logic [1:0]  gnt;
   logic        granted;
   port_id_t    win_id;

   logic        sel_we;
   logic [29:0] sel_idx;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic        req_err;
   logic        full_store;
   logic        part_store;

   logic        resp_valid;
   logic        resp_err;
   port_id_t    resp_id;
   logic [31:0] resp_data;

   port_id_t    mrg_id;
   logic [29:0] mrg_idx;
   logic [31:0] mrg_old;
   logic [31:0] mrg_wdata;
   logic [3:0]  mrg_be;

   // The two low address bits select a byte within the word and are meaningless here.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .advance ((state == IDLE) && !reset),
      .req     ({p1_req, p0_req}),
      .gnt     (gnt)
   );

   assign p0_gnt  = gnt[0];
   assign p1_gnt  = gnt[1];
   assign granted = |gnt;
   assign win_id  = gnt[1];

   always_comb begin
      sel_we    = win_id ? p1_we           : p0_we;
      sel_idx   = win_id ? p1_addr[31:2]   : p0_addr[31:2];
      sel_wdata = win_id ? p1_wdata        : p0_wdata;
      sel_be    = win_id ? p1_be           : p0_be;
   end

   assign req_err    = ({2'b00, sel_idx} >= DEPTH_LIMIT) || (sel_we && (sel_be == 4'h0));
   assign full_store = sel_we && !req_err && (sel_be == 4'hF);
   assign part_store = sel_we && !req_err && (sel_be != 4'hF);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (granted && part_store) state_next = MERGE;
         MERGE: state_next = IDLE;
      endcase
   end

   // Memory-side outputs are forced idle while reset is high so an interrupted merge never writes.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (granted) begin
                  mem_addr = {2'b00, sel_idx};
                  if (full_store) begin
                     mem_we    = 1'b1;
                     mem_wdata = sel_wdata;
                  end
               end
            end
            MERGE: begin
               mem_addr  = {2'b00, mrg_idx};
               mem_we    = 1'b1;
               mem_wdata = byte_merge(mrg_old, mrg_wdata, mrg_be);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         mrg_id     <= 1'b0;
         mrg_idx    <= '0;
         mrg_old    <= '0;
         mrg_wdata  <= '0;
         mrg_be     <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_data  <= '0;
         if (state == MERGE) begin
            resp_valid <= 1'b1;
            resp_id    <= mrg_id;
         end else if (granted) begin
            resp_id <= win_id;
            if (req_err) begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
            end else if (!sel_we) begin
               resp_valid <= 1'b1;
               resp_data  <= mem_rdata;
            end else if (full_store) begin
               resp_valid <= 1'b1;
            end else begin
               mrg_id    <= win_id;
               mrg_idx   <= sel_idx;
               mrg_old   <= mem_rdata;
               mrg_wdata <= sel_wdata;
               mrg_be    <= sel_be;
            end
         end
      end
   end

   assign p0_rvalid = resp_valid && (resp_id == 1'b0);
   assign p1_rvalid = resp_valid && (resp_id == 1'b1);
   assign p0_err    = p0_rvalid && resp_err;
   assign p1_err    = p1_rvalid && resp_err;
   assign p0_rdata  = p0_rvalid ? resp_data : '0;
   assign p1_rdata  = p1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus a random two-port mix,
// with responses checked against a scoreboard queue filled at grant time.
module tb_dmem_ctrl;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset;

   logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic [3:0]  p0_be;
   logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic [3:0]  p1_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];

   typedef struct {
      int          port;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_be     (p0_be),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p0_err    (p0_err),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_be     (p1_be),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .p1_err    (p1_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   // Behavioural single-port memory: combinational read, write on the rising edge.
   assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[9:0]] : 32'h0BAD_0BAD;

   always @(posedge clk) begin
      if (mem_we && mem_addr < DEPTH) mem[mem_addr[9:0]] <= mem_wdata;
   end

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                            input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (new_word & mask) | (old_word & ~mask);
   endfunction

   task automatic drive(input int port, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
      end
   endtask

   task automatic idle_all();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   // Records the response a granted request must produce and applies stores to the reference image.
   task automatic push_expect(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, output logic partial);
      exp_t        e;
      logic [29:0] idx;
      idx     = addr[31:2];
      partial = 1'b0;
      e.port  = port;
      e.err   = 1'b0;
      e.data  = 32'h0;
      if (idx >= DEPTH || (we && be == 4'h0)) begin
         e.err = 1'b1;
      end else if (!we) begin
         e.data = ref_mem[idx[9:0]];
      end else begin
         ref_mem[idx[9:0]] = tb_merge(ref_mem[idx[9:0]], wdata, be);
         partial = (be != 4'hF);
      end
      exp_q.push_back(e);
   endtask

   exp_t        mon_e;
   int          got_port;
   logic        got_err, oth_err;
   logic [31:0] got_data, oth_data;

   always @(negedge clk) begin
      if (mem_we) begin
         checks++;
         if (mem_addr >= DEPTH) begin
            errors++;
            $display("[TB] FAIL mem_we_range: got mem_addr=%h, required < %0d", mem_addr, DEPTH);
         end
      end
      if (p0_rvalid || p1_rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_rvalid: got p0_rvalid=%b p1_rvalid=%b, required none", p0_rvalid, p1_rvalid);
         end else begin
            mon_e    = exp_q.pop_front();
            got_port = p1_rvalid ? 1 : 0;
            got_err  = p1_rvalid ? p1_err : p0_err;
            got_data = p1_rvalid ? p1_rdata : p0_rdata;
            oth_err  = p1_rvalid ? p0_err : p1_err;
            oth_data = p1_rvalid ? p0_rdata : p1_rdata;
            if (p0_rvalid && p1_rvalid) begin
               errors++;
               $display("[TB] FAIL dual_rvalid: got both rvalid high, required one");
            end
            checks++;
            if (got_port != mon_e.port) begin
               errors++;
               $display("[TB] FAIL resp_port: got %0d, required %0d", got_port, mon_e.port);
            end
            checks++;
            if (got_err !== mon_e.err) begin
               errors++;
               $display("[TB] FAIL resp_err: got %b, required %b", got_err, mon_e.err);
            end
            checks++;
            if (got_data !== mon_e.data) begin
               errors++;
               $display("[TB] FAIL resp_rdata: got %h, required %h", got_data, mon_e.data);
            end
            checks++;
            if (oth_err !== 1'b0 || oth_data !== 32'h0) begin
               errors++;
               $display("[TB] FAIL other_port_quiet: got err=%b rdata=%h, required 0/0", oth_err, oth_data);
            end
         end
      end
   end

   task automatic test_reset();
      logic part;
      reset = 1'b1;
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we} !== 7'b0 ||
             p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got gnt=%b%b rvalid=%b%b err=%b%b we=%b addr=%h wdata=%h, required all 0",
                     p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we, mem_addr, mem_wdata);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL first_tie: got gnt=%b%b addr=%h we=%b, required gnt=10 addr=4 we=0", p0_gnt, p1_gnt, mem_addr, mem_we);
      end
      push_expect(0, 1'b0, 32'h10, 32'h0, 4'h0, part);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      checks++;
      if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_addr !== 32'h8 || p0_rvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL second_grant: got gnt=%b%b addr=%h p0_rvalid=%b, required gnt=01 addr=8 p0_rvalid=1",
                  p0_gnt, p1_gnt, mem_addr, p0_rvalid);
      end
      push_expect(1, 1'b0, 32'h20, 32'h0, 4'h0, part);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      checks++;
      if (p1_rvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL p1_rvalid_timing: got %b, required 1", p1_rvalid);
      end
   endtask

   task automatic test_full_store_raw();
      logic part;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL full_store: got gnt=%b we=%b addr=%h wdata=%h, required 1/1/10/deadbeef",
                  p0_gnt, mem_we, mem_addr, mem_wdata);
      end
      push_expect(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, part);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL raw_load_grant: got gnt=%b we=%b, required 1/0", p0_gnt, mem_we);
      end
      push_expect(0, 1'b0, 32'h40, 32'h0, 4'h0, part);
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL raw_load_data: got rvalid=%b rdata=%h, required 1/deadbeef", p0_rvalid, p0_rdata);
      end
   endtask

   task automatic test_partial_store();
      logic part;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'h40, 32'h00AA0000, 4'b0100);
      drive(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      #1;
      checks++;
      if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
         errors++;
         $display("[TB] FAIL partial_grant: got gnt=%b%b we=%b addr=%h, required gnt=01 we=0 addr=10",
                  p0_gnt, p1_gnt, mem_we, mem_addr);
      end
      push_expect(1, 1'b1, 32'h40, 32'h00AA0000, 4'b0100, part);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      checks++;
      if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAABEEF) begin
         errors++;
         $display("[TB] FAIL merge_write: got gnt=%b%b we=%b addr=%h wdata=%h, required 00/1/10/deaabeef",
                  p0_gnt, p1_gnt, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk); #1;
      checks++;
      if (p0_gnt !== 1'b1 || p1_rvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL after_merge: got p0_gnt=%b p1_rvalid=%b, required 1/1", p0_gnt, p1_rvalid);
      end
      push_expect(0, 1'b0, 32'h80, 32'h0, 4'h0, part);
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_errors();
      logic part;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL range_load_grant: got gnt=%b we=%b, required 1/0", p0_gnt, mem_we);
      end
      push_expect(0, 1'b0, 32'h1000, 32'h0, 4'h0, part);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h0);
      #1;
      checks++;
      if (p1_gnt !== 1'b1 || mem_we !== 1'b0 || p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL be0_grant_range_resp: got gnt=%b we=%b p0 rvalid=%b err=%b rdata=%h, required 1/0/1/1/0",
                  p1_gnt, mem_we, p0_rvalid, p0_err, p0_rdata);
      end
      push_expect(1, 1'b1, 32'h40, 32'h12345678, 4'h0, part);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(0, 1'b1, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL range_store: got gnt=%b we=%b, required 1/0", p0_gnt, mem_we);
      end
      push_expect(0, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF, part);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_addr !== 32'h3FF) begin
         errors++;
         $display("[TB] FAIL last_word_grant: got gnt=%b addr=%h, required 1/3ff", p0_gnt, mem_addr);
      end
      push_expect(0, 1'b0, 32'hFFC, 32'h0, 4'h0, part);
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_back_to_back();
      logic part;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
         #1;
         checks++;
         if (p0_gnt !== 1'b1 || (i > 0 && p0_rvalid !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL back_to_back[%0d]: got gnt=%b rvalid=%b, required 1/%b", i, p0_gnt, p0_rvalid, i > 0);
         end
         push_expect(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, part);
      end
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_reset_in_merge();
      logic part;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h80, 32'h00000011, 4'b0001);
      #1;
      checks++;
      if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abandon_grant: got gnt=%b we=%b, required 1/0", p0_gnt, mem_we);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_all();
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abandon_no_write: got mem_we=%b, required 0", mem_we);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abandon_no_resp: got rvalid=%b%b, required 00", p0_rvalid, p1_rvalid);
         end
      end
      drive(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      #1;
      push_expect(0, 1'b0, 32'h80, 32'h0, 4'h0, part);
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (p0_rdata !== init_word(32'h20)) begin
         errors++;
         $display("[TB] FAIL abandon_old_word: got %h, required %h", p0_rdata, init_word(32'h20));
      end
   endtask

   task automatic test_random_mix();
      logic        pend [2];
      logic        rwe  [2];
      logic [31:0] raddr[2];
      logic [31:0] rwd  [2];
      logic [3:0]  rbe  [2];
      logic        tb_last;
      logic        in_merge;
      logic        part;
      logic        exp_we;
      logic [29:0] idx;
      logic [29:0] m_idx;
      logic [31:0] m_word;
      logic [1:0]  exp_gnt;
      int          win;
      int          r;
      pend[0] = 1'b0; pend[1] = 1'b0;
      tb_last  = 1'b0;
      in_merge = 1'b0;
      m_idx    = '0;
      m_word   = '0;
      for (int cyc = 0; cyc < 320; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && cyc < 300 && $urandom_range(0, 2) != 0) begin
               pend[p]  = 1'b1;
               rwe[p]   = 1'($urandom_range(0, 1));
               idx      = ($urandom_range(0, 7) == 0) ? 30'(DEPTH + $urandom_range(0, 50)) : 30'($urandom_range(0, 31));
               raddr[p] = {idx, 2'($urandom_range(0, 3))};
               rwd[p]   = $urandom;
               r        = $urandom_range(0, 7);
               rbe[p]   = (r == 0) ? 4'h0 : (r < 4) ? 4'hF : 4'($urandom_range(1, 14));
            end
            drive(p, pend[p], rwe[p], raddr[p], rwd[p], rbe[p]);
         end
         #1;
         exp_gnt = 2'b00;
         if (!in_merge) begin
            if (pend[0] && pend[1]) exp_gnt = tb_last ? 2'b01 : 2'b10;
            else if (pend[0])       exp_gnt = 2'b01;
            else if (pend[1])       exp_gnt = 2'b10;
         end
         checks++;
         if ({p1_gnt, p0_gnt} !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL rand_gnt@%0d: got %b%b, required %b", cyc, p1_gnt, p0_gnt, exp_gnt);
         end
         if (in_merge) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== {2'b00, m_idx} || mem_wdata !== m_word) begin
               errors++;
               $display("[TB] FAIL rand_merge@%0d: got we=%b addr=%h wdata=%h, required 1/%h/%h",
                        cyc, mem_we, mem_addr, mem_wdata, {2'b00, m_idx}, m_word);
            end
            in_merge = 1'b0;
         end else if (exp_gnt != 2'b00) begin
            win    = exp_gnt[1] ? 1 : 0;
            idx    = raddr[win][31:2];
            exp_we = rwe[win] && rbe[win] == 4'hF && idx < DEPTH;
            checks++;
            if (mem_we !== exp_we || mem_addr !== {2'b00, idx} || (exp_we && mem_wdata !== rwd[win])) begin
               errors++;
               $display("[TB] FAIL rand_mem@%0d: got we=%b addr=%h wdata=%h, required %b/%h/%h",
                        cyc, mem_we, mem_addr, mem_wdata, exp_we, {2'b00, idx}, rwd[win]);
            end
            push_expect(win, rwe[win], raddr[win], rwd[win], rbe[win], part);
            if (part) begin
               in_merge = 1'b1;
               m_idx    = idx;
               m_word   = ref_mem[idx[9:0]];
            end
            pend[win] = 1'b0;
            tb_last   = (win == 1);
         end else begin
            checks++;
            if (mem_we !== 1'b0) begin
               errors++;
               $display("[TB] FAIL rand_idle_we@%0d: got %b, required 0", cyc, mem_we);
            end
         end
      end
      @(negedge clk);
      idle_all();
      checks++;
      if (pend[0] || pend[1]) begin
         errors++;
         $display("[TB] FAIL rand_timeout: got pending=%b%b, required 00", pend[1], pend[0]);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = init_word(i);
         ref_mem[i] = init_word(i);
      end
      test_reset();
      test_full_store_raw();
      test_partial_store();
      test_errors();
      test_back_to_back();
      test_reset_in_merge();
      test_random_mix();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
